top_result_packer: RTL and testbench

TOP_RESULT_PACKER -- requirements
Module: top_result_packer

---
 rtl/top_result_pkg.sv | 23 ++
 rtl/result_fifo.sv | 77 +++++++
 rtl/top_result_packer.sv | 110 +++++++++++
 tb/tb_top_result_packer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/top_result_pkg.sv
`default_nettype none
// ============================================================================
// Module      : top_result_pkg
// Description : Shared widths and the packed FIFO entry type for the result
//               packer (3-bit samples, four per 12-bit word, 3-bit count).
// Revision    : 1.0 - initial release
// ============================================================================
package top_result_pkg;

    localparam int SAMPLE_W = 3;
    localparam int SPW      = 4;
    localparam int WORD_W   = 12;
    localparam int CNT_W    = 3;
    localparam int ENTRY_W  = CNT_W + WORD_W;

    // One FIFO entry: sample count in the upper bits, packed word below.
    typedef struct packed {
        logic [CNT_W-1:0]  cnt;
        logic [WORD_W-1:0] data;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : result_fifo
// Description : First-word-fall-through FIFO. A push into a full FIFO is
//               still accepted when the head is popped on the same edge;
//               otherwise the push is dropped and o_drop is raised.
// Revision    : 1.0 - initial release
// ============================================================================
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic w_valid;
    logic w_pop;
    logic w_full;
    logic w_accept;

    assign w_valid  = (r_level != '0);
    assign w_pop    = w_valid && i_ready;
    assign w_full   = (r_level == LVL_W'(DEPTH));
    assign w_accept = i_push && (!w_full || w_pop);

    assign o_valid  = w_valid;
    assign o_level  = r_level;
    assign o_drop   = i_push && !w_accept;
    // Empty FIFO presents zero rather than stale storage contents.
    assign o_data   = w_valid ? r_mem[r_rd_ptr] : '0;

    // Storage write; contents are meaningless until covered by the level.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/top_result_packer.sv
`default_nettype none
// ============================================================================
// Module      : top_result_packer
// Description : Packs 3-bit {bus_out, out0} samples four to a 12-bit word,
//               supports flushing partial words, and queues words with their
//               sample count in a FWFT FIFO with sticky overflow reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module top_result_packer
    import top_result_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SPW   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_en,
    input  logic                       out0,
    input  logic [1:0]                 bus_out,
    input  logic                       flush,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [11:0]                m_data,
    output logic [2:0]                 m_cnt,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int IDX_W = $clog2(SPW);

    logic [IDX_W-1:0]    r_idx;
    logic [WORD_W-1:0]   r_asm;
    logic                r_overflow;

    logic [SAMPLE_W-1:0] w_sample;
    logic [WORD_W-1:0]   w_asm_next;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_slot_full;
    logic                w_push;
    entry_t              w_push_entry;
    entry_t              w_head;
    logic                w_drop;

    assign w_sample    = {bus_out, out0};
    assign w_cnt_next  = CNT_W'(r_idx) + CNT_W'(sample_en);
    assign w_slot_full = sample_en && (r_idx == IDX_W'(SPW - 1));
    // A flush only produces a word when at least one sample is held.
    assign w_push      = w_slot_full || (flush && (w_cnt_next != '0));

    // Assembly word including this cycle's sample (if any) in slot r_idx.
    always_comb begin
        w_asm_next = r_asm;
        for (int k = 0; k < SPW; k++) begin
            if (sample_en && (r_idx == IDX_W'(k))) begin
                w_asm_next[k*SAMPLE_W +: SAMPLE_W] = w_sample;
            end
        end
    end

    assign w_push_entry.cnt  = w_cnt_next;
    assign w_push_entry.data = w_asm_next;

    // Packer state: clears whenever a word is pushed, dropped or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_asm <= '0;
        end else if (w_push) begin
            r_idx <= '0;
            r_asm <= '0;
        end else if (sample_en) begin
            r_idx <= r_idx + 1'b1;
            r_asm <= w_asm_next;
        end
    end

    result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_ready (m_ready),
        .o_valid (m_valid),
        .o_data  (w_head),
        .o_level (level),
        .o_drop  (w_drop)
    );

    assign m_data = w_head.data;
    assign m_cnt  = w_head.cnt;

    // Sticky overflow; a drop on the same edge beats the clear request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_top_result_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_top_result_packer
// Description : Directed self-checking bench for top_result_packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_top_result_packer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_en;
    logic        out0;
    logic [1:0]  bus_out;
    logic        flush;
    logic        m_valid;
    logic        m_ready;
    logic [11:0] m_data;
    logic [2:0]  m_cnt;
    logic [2:0]  level;
    logic        overflow;
    logic        clr_ovf;

    int checks = 0;
    int passes = 0;

    top_result_packer #(
        .DEPTH (DEPTH),
        .SPW   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .out0      (out0),
        .bus_out   (bus_out),
        .flush     (flush),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_cnt     (m_cnt),
        .level     (level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Capture one 3-bit sample s = {bus_out, out0} on the next edge.
    task automatic send(input logic [2:0] s, input logic fl);
        sample_en = 1'b1;
        out0      = s[0];
        bus_out   = s[2:1];
        flush     = fl;
        tick();
        sample_en = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic send_word(input logic [2:0] s);
        for (int i = 0; i < 4; i++) send(s, 1'b0);
    endtask

    task automatic test_reset();
        #3;
        checks++; if (m_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", m_valid); else passes++;
        checks++; if (level !== 3'd0) $display("FAIL reset_level got %0d exp 0", level); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b exp 0", overflow); else passes++;
        checks++; if ({m_cnt, m_data} !== 15'h0) $display("FAIL reset_head got %h exp 0", {m_cnt, m_data}); else passes++;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_full_word();
        send(3'b001, 1'b0);
        send(3'b010, 1'b0);
        send(3'b101, 1'b0);
        checks++; if (m_valid !== 1'b0) $display("FAIL word_early got valid=%b exp 0", m_valid); else passes++;
        send(3'b110, 1'b0);
        checks++; if (m_valid !== 1'b1) $display("FAIL word_valid got %b exp 1", m_valid); else passes++;
        checks++; if (m_data !== 12'hD51) $display("FAIL word_data got %h exp d51", m_data); else passes++;
        checks++; if (m_cnt !== 3'd4) $display("FAIL word_cnt got %0d exp 4", m_cnt); else passes++;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) $display("FAIL word_pop got valid=%b exp 0", m_valid); else passes++;
    endtask

    task automatic test_flush();
        send(3'b111, 1'b0);
        send(3'b011, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if ({m_valid, m_cnt, m_data} !== {1'b1, 3'd2, 12'h01F})
            $display("FAIL flush_partial got v=%b cnt=%0d data=%h exp v=1 cnt=2 data=01f", m_valid, m_cnt, m_data); else passes++;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (level !== 3'd0) $display("FAIL flush_empty got level=%0d exp 0", level); else passes++;
        // Flush coinciding with the first sample: one-sample word.
        send(3'b101, 1'b1);
        checks++; if ({level, m_cnt, m_data} !== {3'd1, 3'd1, 12'h005})
            $display("FAIL flush_one got lvl=%0d cnt=%0d data=%h exp 1/1/005", level, m_cnt, m_data); else passes++;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        // Flush coinciding with the fourth sample: exactly one full word.
        send(3'b001, 1'b0);
        send(3'b001, 1'b0);
        send(3'b001, 1'b0);
        send(3'b111, 1'b1);
        checks++; if ({level, m_cnt, m_data} !== {3'd1, 3'd4, 12'hE49})
            $display("FAIL flush_full got lvl=%0d cnt=%0d data=%h exp 1/4/e49", level, m_cnt, m_data); else passes++;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++; if (level !== 3'd0) $display("FAIL flush_full_single got level=%0d exp 0", level); else passes++;
    endtask

    task automatic test_overflow();
        logic [2:0] s;
        for (int w = 1; w <= DEPTH + 1; w++) begin
            s = 3'(w);
            send_word(s);
        end
        checks++; if (level !== 3'(DEPTH)) $display("FAIL ovf_level got %0d exp %0d", level, DEPTH); else passes++;
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", overflow); else passes++;
        tick();
        tick();
        checks++; if (m_data !== {4{3'b001}}) $display("FAIL ovf_stable got %h exp 249", m_data); else passes++;
        for (int w = 1; w <= DEPTH; w++) begin
            s = 3'(w);
            checks++; if ({m_valid, m_cnt, m_data} !== {1'b1, 3'd4, {4{s}}})
                $display("FAIL ovf_order%0d got v=%b cnt=%0d data=%h exp data=%h", w, m_valid, m_cnt, m_data, {4{s}}); else passes++;
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
        end
        checks++; if (m_valid !== 1'b0) $display("FAIL ovf_drained got valid=%b exp 0", m_valid); else passes++;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b exp 0", overflow); else passes++;
    endtask

    task automatic test_full_with_pop();
        logic [2:0] s;
        for (int w = 1; w <= DEPTH; w++) begin
            s = 3'(w);
            send_word(s);
        end
        send(3'd5, 1'b0);
        send(3'd5, 1'b0);
        send(3'd5, 1'b0);
        m_ready = 1'b1;
        send(3'd5, 1'b0);
        m_ready = 1'b0;
        checks++; if (overflow !== 1'b0) $display("FAIL fullpop_ovf got %b exp 0", overflow); else passes++;
        checks++; if (level !== 3'(DEPTH)) $display("FAIL fullpop_level got %0d exp %0d", level, DEPTH); else passes++;
        for (int w = 2; w <= DEPTH + 1; w++) begin
            s = 3'(w);
            checks++; if (m_data !== {4{s}}) $display("FAIL fullpop_order%0d got %h exp %h", w, m_data, {4{s}}); else passes++;
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
        end
    endtask

    task automatic test_drop_clr();
        for (int w = 0; w < DEPTH; w++) send_word(3'd2);
        send(3'd3, 1'b0);
        send(3'd3, 1'b0);
        send(3'd3, 1'b0);
        clr_ovf = 1'b1;
        send(3'd3, 1'b0);
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b1) $display("FAIL dropclr_set got %b exp 1", overflow); else passes++;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) $display("FAIL dropclr_clear got %b exp 0", overflow); else passes++;
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        m_ready = 1'b0;
        checks++; if (level !== 3'd0) $display("FAIL dropclr_drain got level=%0d exp 0", level); else passes++;
    endtask

    task automatic test_async_reset();
        send_word(3'd1);
        send_word(3'd2);
        send_word(3'd3);
        send(3'd4, 1'b0);
        send(3'd4, 1'b0);
        checks++; if (level !== 3'd3) $display("FAIL areset_pre got level=%0d exp 3", level); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if ({m_valid, level} !== {1'b0, 3'd0})
            $display("FAIL areset_async got v=%b lvl=%0d exp v=0 lvl=0", m_valid, level); else passes++;
        tick();
        rst_n = 1'b1;
        send(3'd6, 1'b0);
        send(3'd7, 1'b0);
        send(3'd0, 1'b0);
        checks++; if (level !== 3'd0) $display("FAIL areset_nostale got level=%0d exp 0", level); else passes++;
        send(3'd1, 1'b0);
        checks++; if ({level, m_cnt, m_data} !== {3'd1, 3'd4, 12'h23E})
            $display("FAIL areset_word got lvl=%0d cnt=%0d data=%h exp 1/4/23e", level, m_cnt, m_data); else passes++;
    endtask

    initial begin
        rst_n     = 1'b0;
        sample_en = 1'b0;
        out0      = 1'b0;
        bus_out   = 2'b00;
        flush     = 1'b0;
        m_ready   = 1'b0;
        clr_ovf   = 1'b0;
        test_reset();
        test_full_word();
        test_flush();
        test_overflow();
        test_full_with_pop();
        test_drop_clr();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
